switch_scan_ctrl: RTL



---
 rtl/switch_scan_ctrl_if.sv | 30 +++
 rtl/switch_scan_ctrl.sv | 120 ++++++++++++
 2 files changed

// File: rtl/switch_scan_ctrl_if.sv
// Switch-bank bundle: raw inputs in, debounced levels and edge pulses out.
// master = the scanning debouncer, slave = the consumer that drives raw inputs and reads results.
interface switch_scan_ctrl_if #(
    parameter int N = 4
);
    logic [N-1:0] switch_in;
    logic [N-1:0] switch_out;
    logic [N-1:0] press_pulse;
    logic [N-1:0] release_pulse;
    logic         scan_busy;
    logic         scan_done;

    modport master (
        input  switch_in,
        output switch_out,
        output press_pulse,
        output release_pulse,
        output scan_busy,
        output scan_done
    );

    modport slave (
        output switch_in,
        input  switch_out,
        input  press_pulse,
        input  release_pulse,
        input  scan_busy,
        input  scan_done
    );
endinterface

// File: rtl/switch_scan_ctrl.sv
// Time-multiplexed debouncer: a prescaler tick starts a sweep that visits one channel per clock.
// Channel i updates i+2 clocks after the prescaler all-ones cycle; no backpressure, outputs are free-running.
module switch_scan_ctrl #(
    parameter int N            = 4,
    parameter int DIV_WIDTH    = 8,
    parameter int STABLE_COUNT = 8,
    parameter bit ACTIVE_LOW   = 1'b1
) (
    input  logic                 sys_clock,
    input  logic                 sys_rst_n,
    switch_scan_ctrl_if.master   sw
);
    localparam logic REL = ACTIVE_LOW;
    localparam int   CW  = $clog2(STABLE_COUNT);
    localparam int   IW  = (N > 1) ? $clog2(N) : 1;

    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(STABLE_COUNT - 1);

    // A tick during SCAN would be missed, so a sweep must finish inside one prescaler period.
    if (N < 1 || N > 16 || N >= (1 << DIV_WIDTH)) begin : g_bad_n
        $error("switch_scan_ctrl: N must be 1..16 and smaller than 2**DIV_WIDTH");
    end
    if (STABLE_COUNT < 2 || STABLE_COUNT > 15) begin : g_bad_count
        $error("switch_scan_ctrl: STABLE_COUNT must be 2..15");
    end

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t               r_state;
    logic [DIV_WIDTH-1:0] r_presc;
    logic [IW-1:0]        r_idx;
    logic [N-1:0]         r_sync1;
    logic [N-1:0]         r_sync2;
    logic [N-1:0]         r_out;
    logic [N-1:0]         r_press;
    logic [N-1:0]         r_rel;
    logic                 r_busy;
    logic                 r_done;
    logic [CW-1:0]        r_cnt [N];

    logic w_mismatch;
    logic w_cnt_full;

    assign w_mismatch = (r_sync2[r_idx] != r_out[r_idx]);
    assign w_cnt_full = (r_cnt[r_idx] == CNT_MAX);

    always_ff @(posedge sys_clock or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state <= IDLE;
            r_presc <= '0;
            r_idx   <= '0;
            r_sync1 <= {N{REL}};
            r_sync2 <= {N{REL}};
            r_out   <= {N{REL}};
            r_press <= '0;
            r_rel   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            for (int i = 0; i < N; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_sync1 <= sw.switch_in;
            r_sync2 <= r_sync1;
            r_presc <= r_presc + DIV_WIDTH'(1);
            r_press <= '0;
            r_rel   <= '0;
            r_done  <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (r_presc == '1) begin
                        r_state <= SCAN;
                        r_idx   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                SCAN: begin
                    // Any sweep where the input agrees with the accepted level restarts the count.
                    if (w_mismatch) begin
                        if (w_cnt_full) begin
                            r_out[r_idx] <= r_sync2[r_idx];
                            r_cnt[r_idx] <= '0;
                            if (r_sync2[r_idx] != REL) begin
                                r_press[r_idx] <= 1'b1;
                            end else begin
                                r_rel[r_idx] <= 1'b1;
                            end
                        end else begin
                            r_cnt[r_idx] <= r_cnt[r_idx] + CW'(1);
                        end
                    end else begin
                        r_cnt[r_idx] <= '0;
                    end

                    if (r_idx == LAST_IDX) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_idx <= r_idx + IW'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign sw.switch_out    = r_out;
    assign sw.press_pulse   = r_press;
    assign sw.release_pulse = r_rel;
    assign sw.scan_busy     = r_busy;
    assign sw.scan_done     = r_done;
endmodule
